// File: rtl/psram_pkg.sv
// Shared types and constants for the byte-serial PSRAM command front end.
// The FSM state encoding and command opcodes live here so the top and any tooling agree.
package psram_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WREQ,
    ST_RREQ,
    ST_RWAIT,
    ST_RDATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         ADDR_BYTES = 3;

endpackage

// File: rtl/psram_byte_front.sv
// Byte-serial command front end: decodes framed WRITE/READ commands, packs write bytes
// into 32-bit word writes and streams read words back out one byte at a time.
module psram_byte_front
  import psram_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          ram_wr_req,
  input  logic          ram_wr_ack,
  output logic          ram_rd_req,
  input  logic          ram_rd_ack,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          busy,
  output logic          drop
);

  state_e        state;
  logic [1:0]    cnt;
  logic          op_write;
  logic [15:0]   addr_hi;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rbuf;
  logic          end_pending;
  logic          drop_q;

  logic          in_fire;
  logic          out_fire;
  logic [23:0]   byte_addr;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign byte_addr = {addr_hi, in_data};

  // A frame end seen while a request is outstanding is remembered until the ack,
  // because the request itself must never be withdrawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      addr_hi     <= '0;
      addr        <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      end_pending <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all branches see pre-edge values.
      case (state)
        ST_IDLE: begin
          cnt         <= '0;
          end_pending <= 1'b0;
          if (!cs_n) state <= ST_CMD;
        end

        ST_CMD: begin
          if (cs_n) begin
            state <= ST_IDLE;
          end else if (in_fire) begin
            cnt <= '0;
            if (in_data == CMD_WRITE) begin
              op_write <= 1'b1;
              state    <= ST_ADDR;
            end else if (in_data == CMD_READ) begin
              op_write <= 1'b0;
              state    <= ST_ADDR;
            end else begin
              state <= ST_IGNORE;
            end
          end
        end

        ST_ADDR: begin
          if (cs_n) begin
            state <= ST_IDLE;
          end else if (in_fire) begin
            if (cnt == 2'(ADDR_BYTES - 1)) begin
              addr  <= AW'(byte_addr >> 2);
              cnt   <= '0;
              state <= op_write ? ST_WDATA : ST_RREQ;
            end else begin
              addr_hi <= {addr_hi[7:0], in_data};
              cnt     <= cnt + 2'd1;
            end
          end
        end

        ST_WDATA: begin
          if (cs_n) begin
            if (cnt != 2'd0) drop_q <= 1'b1;
            state <= ST_IDLE;
          end else if (in_fire) begin
            wdata <= {in_data, wdata[31:8]};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3) state <= ST_WREQ;
          end
        end

        ST_WREQ: begin
          if (cs_n) end_pending <= 1'b1;
          if (ram_wr_ack) begin
            addr  <= addr + AW'(1);
            state <= (cs_n || end_pending) ? ST_IDLE : ST_WDATA;
          end
        end

        ST_RREQ: begin
          if (cs_n) end_pending <= 1'b1;
          if (ram_rd_ack) state <= (cs_n || end_pending) ? ST_IDLE : ST_RWAIT;
        end

        ST_RWAIT: begin
          if (cs_n) begin
            state <= ST_IDLE;
          end else begin
            rbuf  <= ram_rdata;
            cnt   <= '0;
            state <= ST_RDATA;
          end
        end

        ST_RDATA: begin
          if (cs_n) begin
            state <= ST_IDLE;
          end else if (out_fire) begin
            rbuf <= {8'h00, rbuf[31:8]};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              addr  <= addr + AW'(1);
              state <= ST_RREQ;
            end
          end
        end

        ST_IGNORE: begin
          if (cs_n) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
  assign in_ready   = rst_n & (state != ST_WREQ);
  assign busy       = (state != ST_IDLE);
  assign out_valid  = (state == ST_RDATA);
  assign out_data   = rbuf[7:0];
  assign ram_wr_req = (state == ST_WREQ);
  assign ram_rd_req = (state == ST_RREQ);
  assign ram_addr   = addr;
  assign ram_wdata  = wdata;
  assign drop       = drop_q;

endmodule

// File: tb/tb_psram_byte_front.sv
// Scoreboard bench for psram_byte_front: stimulus pushes expected word writes and read
// bytes from a word-array reference; a monitor plays the RAM and compares handshakes.
module tb_psram_byte_front;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          out_ready = 1'b0;
  logic          ram_wr_ack = 1'b0;
  logic          ram_rd_ack = 1'b0;
  logic [31:0]   ram_rdata = '0;
  logic          in_ready, out_valid, ram_wr_req, ram_rd_req, busy, drop;
  logic [7:0]    out_data;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;

  psram_byte_front #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_wr_req(ram_wr_req), .ram_wr_ack(ram_wr_ack),
    .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  wr_t         exp_wr[$];
  logic [7:0]  exp_out[$];
  logic [7:0]  wbytes[$];
  bit          ref_drop = 1'b0;
  int          ack_delay = 0;
  int          or_mode = 0;
  int          rd_remaining = 0;
  int          req_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [AW-1:0] word_of(input logic [23:0] ba);
    return AW'((int'(ba) / 4) % DEPTH);
  endfunction

  function automatic logic [AW-1:0] next_word(input logic [AW-1:0] wa);
    return AW'((int'(wa) + 1) % DEPTH);
  endfunction

  // RAM responder and scoreboard monitor: samples at negedge, drives at posedge+1.
  initial begin
    int            wait_cnt = 0;
    bit            rd_hs;
    logic [AW-1:0] rd_a;
    wr_t           w;
    forever begin
      @(negedge clk);
      rd_hs = ram_rd_req && ram_rd_ack;
      rd_a  = ram_addr;
      if (ram_wr_req || ram_rd_req) req_seen++;
      check("req_exclusive", {31'd0, ram_wr_req & ram_rd_req}, 32'd0);
      if (ram_wr_req && ram_wr_ack) begin
        ram_mem[ram_addr] = ram_wdata;
        if (exp_wr.size() == 0) begin
          fail_now($sformatf("wr_unexpected addr=%h data=%h, expected no write", ram_addr, ram_wdata));
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(w.addr));
          check("wr_data", ram_wdata, w.data);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) fail_now($sformatf("out_unexpected byte=%h, expected none", out_data));
        else check("out_byte", 32'(out_data), 32'(exp_out.pop_front()));
        if (rd_remaining > 0) rd_remaining--;
      end
      @(posedge clk);
      #1;
      ram_rdata = rd_hs ? ram_mem[rd_a] : $urandom;
      if (ram_wr_req || ram_rd_req) begin
        if (wait_cnt >= ack_delay) begin
          ram_wr_ack = ram_wr_req;
          ram_rd_ack = ram_rd_req;
          wait_cnt   = 0;
        end else begin
          ram_wr_ack = 1'b0;
          ram_rd_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        ram_wr_ack = 1'b0;
        ram_rd_ack = 1'b0;
        wait_cnt   = 0;
      end
      out_ready = (rd_remaining > 0) && (or_mode == 0 || $urandom_range(0, 1) == 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) fail_now("send_timeout: in_ready never high");
    in_valid = 1'b0;
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    tick();
  endtask

  task automatic frame_end();
    int n = 0;
    cs_n = 1'b1;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) fail_now("frame_end_timeout: busy stuck high");
    tick();
    check("drop_flag", {31'd0, drop}, {31'd0, ref_drop});
  endtask

  task automatic wait_consumed();
    int n = 0;
    while (rd_remaining > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (rd_remaining > 0) begin
      fail_now($sformatf("read_timeout: %0d bytes still owed", rd_remaining));
      rd_remaining = 0;
    end
  endtask

  task automatic do_write(input logic [23:0] ba, input int nbytes, input bit timing_chk);
    logic [AW-1:0] wa = word_of(ba);
    logic [31:0]   word = '0;
    logic [7:0]    b;
    wr_t           w;
    frame_begin();
    send(8'h02);
    send(ba[23:16]);
    send(ba[15:8]);
    send(ba[7:0]);
    for (int i = 0; i < nbytes; i++) begin
      b = (wbytes.size() != 0) ? wbytes.pop_front() : 8'($urandom);
      word = word | (32'(b) << (8 * (i % 4)));
      if (i % 4 == 3) begin
        w.addr = wa;
        w.data = word;
        exp_wr.push_back(w);
        ref_mem[wa] = word;
        wa   = next_word(wa);
        word = '0;
      end
      send(b);
      if (timing_chk && i == 3) begin
        check("wr_req_next_cycle", {31'd0, ram_wr_req}, 32'd1);
        check("in_ready_low_in_wreq", {31'd0, in_ready}, 32'd0);
        tick();
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
        check("wr_req_released", {31'd0, ram_wr_req}, 32'd0);
      end
    end
    if (nbytes % 4 != 0) ref_drop = 1'b1;
    frame_end();
  endtask

  task automatic do_read(input logic [23:0] ba, input int nbytes, input bit timing_chk,
                         input int hold_after, input bit vdrop_chk);
    logic [AW-1:0] wa = word_of(ba);
    logic [31:0]   wv;
    logic [7:0]    first;
    int            n = 0;
    for (int i = 0; i < nbytes; i++) begin
      wv = ref_mem[AW'((int'(wa) + i / 4) % DEPTH)];
      exp_out.push_back(8'(wv >> (8 * (i % 4))));
    end
    first = exp_out[0];
    rd_remaining = (hold_after > 0) ? hold_after : nbytes;
    frame_begin();
    send(8'h03);
    send(ba[23:16]);
    send(ba[15:8]);
    send(ba[7:0]);
    if (timing_chk) begin
      check("rd_req_next_cycle", {31'd0, ram_rd_req}, 32'd1);
      tick();
      check("rwait_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("first_valid_n3", {31'd0, out_valid}, 32'd1);
      check("first_byte_n3", 32'(out_data), 32'(first));
    end
    wait_consumed();
    if (hold_after > 0) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data_stable", 32'(out_data), 32'(exp_out[0]));
      end
      rd_remaining = nbytes - hold_after;
      wait_consumed();
    end
    if (vdrop_chk) begin
      while (!out_valid && n < 50) begin
        tick();
        n++;
      end
      check("prefetch_valid", {31'd0, out_valid}, 32'd1);
      cs_n = 1'b1;
      tick();
      check("valid_drops_after_cs", {31'd0, out_valid}, 32'd0);
    end
    frame_end();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          req0;
    logic [23:0] ba;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[4] = 32'hA1B2_C3D4;
    ref_mem[4] = 32'hA1B2_C3D4;

    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_wr_req", {31'd0, ram_wr_req}, 32'd0);
    check("rst_rd_req", {31'd0, ram_rd_req}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Read of mem[4] with prompt ack, then the prefetched word 5.
    do_read(24'h000010, 8, 1'b1, 0, 1'b1);

    wbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(24'h000010, 4, 1'b1);
    do_read(24'h000010, 4, 1'b0, 0, 1'b0);

    // Wrap from the top word to word 0.
    do_write(24'h07FFFC, 8, 1'b0);
    do_read(24'h07FFFC, 8, 1'b0, 0, 1'b0);

    // Partial trailing word is dropped and the flag sticks.
    do_write(24'h000040, 6, 1'b0);
    do_read(24'h000040, 8, 1'b0, 0, 1'b0);

    // Slow ack and out_ready held low mid-word.
    ack_delay = 3;
    do_read(24'h000100, 8, 1'b0, 2, 1'b0);
    ack_delay = 0;

    req0 = req_seen;
    frame_begin();
    send(8'h9F);
    send(8'h02);
    send(8'h03);
    send(8'h00);
    send(8'h55);
    frame_end();
    check("ignore_no_request", 32'(req_seen), 32'(req0));

    // Reset while a write request is pending.
    ack_delay = 50;
    frame_begin();
    send(8'h02);
    send(8'h00);
    send(8'h00);
    send(8'h20);
    for (int i = 0; i < 4; i++) send(8'($urandom));
    check("wreq_before_reset", {31'd0, ram_wr_req}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    ref_drop = 1'b0;
    check("rst_mid_wr_req", {31'd0, ram_wr_req}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_drop", {31'd0, drop}, 32'd0);
    check("rst_mid_addr", 32'(ram_addr), 32'd0);
    check("rst_mid_wdata", ram_wdata, 32'd0);
    tick();
    cs_n = 1'b1;
    rst_n = 1'b1;
    ack_delay = 0;
    tick();
    tick();
    check("rst_mid_in_ready_back", {31'd0, in_ready}, 32'd1);
    do_write(24'h000020, 4, 1'b0);
    do_read(24'h000020, 4, 1'b0, 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      ack_delay = $urandom_range(0, 3);
      or_mode   = $urandom_range(0, 1);
      ba        = {5'($urandom), 19'($urandom_range(0, 255))};
      if ($urandom_range(0, 2) == 0) do_read(ba, $urandom_range(1, 10), 1'b0, 0, 1'b0);
      else                           do_write(ba, $urandom_range(1, 12), 1'b0);
    end

    tick();
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("out_queue_drained", 32'(exp_out.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psram_byte_front.md
# psram_byte_front

Byte-serial command front end that sits directly upstream of the PSRAM word-memory model and drives its ram_* request/ack port. It receives framed command bytes from the bus deserializer and decodes write and read commands with a 24-bit byte address. Write data bytes are packed into 32-bit words and issued as word writes. Read words are fetched and returned one byte at a time under output backpressure.

## Interface
Parameters:
- AW, 17, word-address width of ram_addr; the byte address maps as word address = byte_addr[AW+1:2].

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cs_n  in  1  frame select, active low, synchronous to clk.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- in_data  in  8  command/address/data byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  8  read byte.
- ram_wr_req  out  1  word write request.
- ram_wr_ack  in  1  write accepted.
- ram_rd_req  out  1  word read request.
- ram_rd_ack  in  1  read accepted.
- ram_addr  out  AW  word address.
- ram_wdata  out  32  write word.
- ram_rdata  in  32  read word, valid the cycle after the rd handshake cycle.
- busy  out  1  state != IDLE.
- drop  out  1  sticky flag: a frame ended with 1-3 unwritten bytes.

## Operation
- Commands: 8'h02 = WRITE, 8'h03 = READ. Any other value goes to IGNORE until cs_n rises.
- Address: 3 bytes, MSB first, giving byte_addr[23:0]. byte_addr[1:0] are ignored, so words are always aligned. Address bits above AW+1 are ignored.
- States:
  - IDLE: on cs_n=0 go to CMD. Bytes seen while cs_n=1 are accepted and discarded.
  - CMD: on the first accepted byte, decode the command and go to ADDR or IGNORE.
  - ADDR: a 2-bit counter takes 3 bytes. After the third byte, WRITE goes to WDATA and READ goes to RREQ.
  - WDATA: pack bytes little-endian (first byte goes to wdata[7:0]). The 4th byte goes to WREQ.
  - WREQ: hold ram_wr_req with stable addr/wdata until ram_wr_ack is sampled high. Then increment the address and return to WDATA.
  - RREQ: hold ram_rd_req until ram_rd_ack, then go to RWAIT.
  - RWAIT: load a 32-bit shift register from ram_rdata and go to RDATA.
  - RDATA: present bytes LSB first. After the 4th accepted byte, increment the address and go to RREQ (streaming prefetch).
  - IGNORE: accept and discard bytes.
- Input bytes during RREQ/RWAIT/RDATA are accepted and discarded (dummy bytes).
- in_ready = 0 only in WREQ; 1 in every other state.
- Address increment wraps modulo 2^AW.
- cs_n=1 mid-frame: the next state is IDLE, with these exceptions:
  - In WREQ or RREQ, the request is never withdrawn. The handshake completes first, then the block goes to IDLE and discards any read data.
  - If WDATA holds 1-3 packed bytes, they are discarded and drop is set.
- out_valid is 0 outside RDATA; it drops in the cycle after cs_n=1 is sampled.
- Reset mid-operation aborts immediately. No request is held across reset.

## Timing
- Reset values: in_ready 0 while rst_n low, 1 after; all other outputs 0. State IDLE, byte counter 0.
- Write: 4th data byte accepted at cycle N → ram_wr_req=1 in N+1. With same-cycle ack, in_ready returns in N+2. Sustained write rate is 4 bytes per 5 cycles.
- Read: 3rd address byte accepted at N → ram_rd_req in N+1 (ack same cycle) → RWAIT in N+2 (capture ram_rdata) → out_valid with byte 0 in N+3.
- A slow ack stretches WREQ/RREQ with no other effect.
- An out_data byte advances only on out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- ram_rd_req and ram_wr_req are never high in the same cycle.

## Structure
- psram_pkg: state enum, CMD_WRITE/CMD_READ constants, ADDR_BYTES=3.
- Single module with no sub-module. Packer and unpacker are plain shift registers inside the FSM.

## Test plan
- WRITE 02 00 00 10, then bytes 11 22 33 44 → one ram_wr_req with addr=4, wdata=32'h44332211. in_ready is low for exactly one cycle.
- READ 03 00 00 10 with mem[4]=32'hA1B2C3D4, out_ready=1 → out bytes D4 C3 B2 A1. First out_valid arrives 3 cycles after the last address byte. Prefetch of addr 5 follows.
- WRITE at byte addr 24'h07FFFC (AW=17), 8 data bytes → writes at word 17'h1FFFF then 17'h00000 (wrap).
- WRITE with 6 data bytes then cs_n=1 → exactly one write. drop=1, and stays set through the next frame.
- Read with out_ready held low for 5 cycles mid-word, and a slow ram_rd_ack (3-cycle delay) → out_data stable, no lost or duplicated bytes. Output order matches memory.
- Command 8'h9F, and separately rst_n pulsed low during WREQ → no ram request is issued. Outputs return to reset values at once, and the next frame decodes correctly.
